tick_gen: RTL and testbench

Parametrised synchronous tick generator for the stopwatch timebase: it replaces ripple-clocked divider chains with a single-clock counter that emits one-cycle clock-enable pulses. Downstream counters stay on `clock` and qualify on `tick` / `tick_dec`. The divisor is runtime-programmable with glitch-free changeover at the period boundary, and a decade sub-divider provides a second, slower enable.

---
 rtl/tick_gen.sv | 132 +++++++++++++
 tb/tb_tick_gen.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// Single-clock timebase: programmable divider emitting tick/tick_dec enables.
// Optional square-wave output on clk_sq when TICK_GEN_SQUARE_EN is defined.
module tick_gen #(
    parameter int WIDTH       = 19,
    parameter int DEFAULT_DIV = 500000,
    parameter int DEC         = 10
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             tick,
    output logic             tick_dec,
    output logic             div_pend,
    output logic             div_err,
    output logic             clk_sq
);

    localparam int DW = $clog2(DEC);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [DW-1:0]    D_LAST  = DW'(DEC - 1);
    localparam logic [DW-1:0]    D_ONE   = DW'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [WIDTH-1:0] div_reg_q, div_reg_d;
    logic [WIDTH-1:0] div_nxt_q, div_nxt_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             tick_q, tick_d;
    logic             tdec_q, tdec_d;
    logic             wrap;
    logic             load_ok;
    logic             swap;

    assign wrap    = en && !clr && (cnt_q == div_reg_q - ONE);
    assign load_ok = div_load && (div_in >= MIN_DIV);
    assign swap    = wrap || clr;

    always_comb begin
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        div_reg_d = div_reg_q;
        div_nxt_d = div_nxt_q;
        pend_d    = pend_q;
        err_d     = div_load && !load_ok;
        tick_d    = wrap;
        tdec_d    = wrap && (dcnt_q == D_LAST);

        if (clr) begin
            cnt_d  = '0;
            dcnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
            if (wrap) begin
                dcnt_d = (dcnt_q == D_LAST) ? '0 : dcnt_q + D_ONE;
            end
        end

        // A load landing on the changeover edge beats the older pending value
        if (swap) begin
            if (load_ok) begin
                div_reg_d = div_in;
                div_nxt_d = div_in;
                pend_d    = 1'b0;
            end else if (pend_q) begin
                div_reg_d = div_nxt_q;
                pend_d    = 1'b0;
            end
        end else if (load_ok) begin
            div_nxt_d = div_in;
            pend_d    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q     <= '0;
            dcnt_q    <= '0;
            div_reg_q <= DIV_RST;
            div_nxt_q <= DIV_RST;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            tick_q    <= 1'b0;
            tdec_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            div_reg_q <= div_reg_d;
            div_nxt_q <= div_nxt_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            tick_q    <= tick_d;
            tdec_q    <= tdec_d;
        end
    end

`ifdef TICK_GEN_SQUARE_EN
    logic sq_q, sq_d;

    always_comb begin
        sq_d = sq_q;
        if (clr) begin
            sq_d = 1'b0;
        end else if (wrap) begin
            sq_d = !sq_q;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign clk_sq = sq_q;
`else
    assign clk_sq = 1'b0;
`endif

    assign tick     = tick_q;
    assign tick_dec = tdec_q;
    assign div_pend = pend_q;
    assign div_err  = err_q;

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen with WIDTH=19, DEFAULT_DIV=4, DEC=3.
// Expected vectors are {tick, tick_dec, div_pend, div_err, clk_sq} per cycle.
module tb_tick_gen;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [18:0] div_in = '0;
    logic        div_load = 1'b0;
    logic        tick, tick_dec, div_pend, div_err, clk_sq;

    typedef struct {
        string      name;
        logic [4:0] v;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    k = 0;
    string scen = "init";

    tick_gen #(.WIDTH(19), .DEFAULT_DIV(4), .DEC(3)) dut (
        .clock(clock), .rst(rst), .en(en), .clr(clr),
        .div_in(div_in), .div_load(div_load),
        .tick(tick), .tick_dec(tick_dec), .div_pend(div_pend),
        .div_err(div_err), .clk_sq(clk_sq)
    );

    always #5 clock = ~clock;

    // Monitor: one popped vector per clock edge that has stimulus behind it
    initial begin
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(posedge clock);
            if (exp_q.size() > 0) begin
                #1;
                e   = exp_q.pop_front();
                act = {tick, tick_dec, div_pend, div_err, clk_sq};
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s got %b want %b (tick,dec,pend,err,sq)",
                             e.name, act, e.v);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic c,
                       input logic l, input logic [18:0] d,
                       input logic [4:0] x);
        exp_t it;
        @(negedge clock);
        rst = r; en = e; clr = c; div_load = l; div_in = d;
        k = r ? 0 : k + 1;
        it.name = $sformatf("%s.c%0d", scen, k);
`ifdef TICK_GEN_SQUARE_EN
        it.v = x;
`else
        it.v = {x[4:1], 1'b0};
`endif
        exp_q.push_back(it);
    endtask

    task automatic rs(input string s);
        scen = s;
        cyc(1, 0, 0, 0, 0, 5'b00000);
    endtask

    task automatic run(input int n, input logic [4:0] x);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, x);
    endtask

    task automatic ld(input logic [18:0] d, input logic [4:0] x);
        cyc(0, 1, 0, 1, d, x);
    endtask

    initial begin
        rs("rst"); rs("rst");

        scen = "dflt";
        run(3, 5'b00000); run(1, 5'b10001);
        run(3, 5'b00001); run(1, 5'b10000);
        run(3, 5'b00000); run(1, 5'b11001);

        rs("load");
        run(2, 5'b00000);
        ld(6, 5'b00100);
        run(1, 5'b10001); run(5, 5'b00001);
        run(1, 5'b10000); run(5, 5'b00000);
        run(1, 5'b11001);

        rs("rej");
        run(1, 5'b00000);
        ld(1, 5'b00010);
        run(1, 5'b00000); run(1, 5'b10001);
        run(3, 5'b00001); run(1, 5'b10000);
        ld(7, 5'b00100); ld(5, 5'b00100);
        run(1, 5'b00100); run(1, 5'b11001);
        ld(0, 5'b00011);
        run(3, 5'b00001); run(1, 5'b10000);

        rs("pause");
        run(2, 5'b00000);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 5'b00000);
        run(1, 5'b00000); run(1, 5'b10001);
        cyc(0, 0, 0, 0, 0, 5'b00001);
        run(3, 5'b00001); run(1, 5'b10000);

        rs("wrapld");
        run(1, 5'b00000);
        ld(7, 5'b00100);
        run(1, 5'b00100);
        ld(5, 5'b10001);
        run(4, 5'b00001); run(1, 5'b10000);

        scen = "clr";
        run(1, 5'b00000);
        ld(4, 5'b00100);
        cyc(0, 1, 1, 0, 0, 5'b00000);
        run(3, 5'b00000); run(1, 5'b10001);
        run(3, 5'b00001); run(1, 5'b10000);
        run(3, 5'b00000); run(1, 5'b11001);

        @(negedge clock);
        rst = 1'b1; en = 1'b0; div_load = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
